// File: rtl/dcp_tx_fmt_if.sv
// Print-request handshake from a command processor, plus the byte stream to the UART transmitter.
// The slave modport is the formatter; the master modport is the requester/UART side.
interface dcp_tx_fmt_if;
  logic        req_tx;
  logic        type_tx;
  logic [31:0] din_tx;
  logic        ack_tx;
  logic        busy;
  logic [7:0]  tx_byte;
  logic        tx_vld;
  logic        tx_rdy;

  modport master (
    output req_tx, type_tx, din_tx, tx_rdy,
    input  ack_tx, busy, tx_byte, tx_vld
  );

  modport slave (
    input  req_tx, type_tx, din_tx, tx_rdy,
    output ack_tx, busy, tx_byte, tx_vld
  );
endinterface

// File: rtl/dcp_tx_fmt.sv
// Debug-command print responder: renders one raw byte, or one 32-bit word as 8 hex characters
// (MS nibble first), onto a valid/ready byte stream and acks once the last character is taken.
module dcp_tx_fmt #(
  parameter bit HEX_UPPER = 1'b1
) (
  input logic         clk,
  input logic         rst,
  dcp_tx_fmt_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StSend, StAck, StRel} state_e;

  state_e      state_q, state_d;
  logic [31:0] sh_q, sh_d;
  logic        mode_q, mode_d;
  logic [2:0]  cnt_q, cnt_d;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    logic [7:0] alpha_base;
    alpha_base = HEX_UPPER ? 8'h41 : 8'h61;
    if (n < 4'd10) begin
      return 8'h30 + {4'h0, n};
    end
    return alpha_base + {4'h0, n} - 8'd10;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      sh_q    <= '0;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (bus.req_tx) begin
          sh_d    = bus.din_tx;
          mode_d  = bus.type_tx;
          cnt_d   = bus.type_tx ? 3'd7 : 3'd0;
          state_d = StSend;
        end
      end
      StSend: begin
        // tx_vld is high throughout this state, so tx_rdy alone completes the handshake
        if (bus.tx_rdy) begin
          if (cnt_q == 3'd0) begin
            state_d = StAck;
          end else begin
            cnt_d = cnt_q - 3'd1;
            sh_d  = sh_q << 4;
          end
        end
      end
      StAck: begin
        state_d = StRel;
      end
      StRel: begin
        // Requester drops req_tx a cycle after ack; wait for it so the request is not re-taken
        if (!bus.req_tx) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs depend only on registered state
  always_comb begin
    bus.tx_vld  = (state_q == StSend);
    bus.ack_tx  = (state_q == StAck);
    bus.busy    = (state_q != StIdle);
    bus.tx_byte = 8'h00;
    if (state_q == StSend) begin
      bus.tx_byte = mode_q ? hex_char(sh_q[31:28]) : sh_q[7:0];
    end
  end

endmodule

// File: tb/tb_dcp_tx_fmt.sv
// Randomized bench for dcp_tx_fmt: upper- and lower-case instances share stimulus and are checked
// against character strings built from the request with a digit lookup table.
module tb_dcp_tx_fmt;

  logic clk;
  logic rst;

  dcp_tx_fmt_if up_if ();
  dcp_tx_fmt_if lo_if ();

  assign lo_if.req_tx  = up_if.req_tx;
  assign lo_if.type_tx = up_if.type_tx;
  assign lo_if.din_tx  = up_if.din_tx;
  assign lo_if.tx_rdy  = up_if.tx_rdy;

  dcp_tx_fmt #(.HEX_UPPER(1'b1)) u_dut_up (.clk(clk), .rst(rst), .bus(up_if.slave));
  dcp_tx_fmt #(.HEX_UPPER(1'b0)) u_dut_lo (.clk(clk), .rst(rst), .bus(lo_if.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;
  logic [7:0] stream_q[$];

  string digits_up = "0123456789ABCDEF";
  string digits_lo = "0123456789abcdef";

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit pick_rdy(input int mode, input int k);
    case (mode)
      0:       return 1'b1;
      1:       return 1'($urandom_range(0, 1));
      default: return (k % 3) == 0;
    endcase
  endfunction

  // One request: rdy_mode 0 = tied high, 1 = random, 2 = one cycle in three.
  // hold = cycles req_tx stays high after ack; early = drop req_tx right after acceptance.
  task automatic run_req(input bit typ, input logic [31:0] d, input int rdy_mode,
                         input int hold, input bit early);
    logic [7:0] exp_up[$];
    logic [7:0] exp_lo[$];
    logic [7:0] held_up, held_lo;
    int k, hs, hs_lo, acks, ack_k, nib;
    bit stall, r;
    if (typ) begin
      for (int i = 0; i < 8; i++) begin
        nib = int'((d >> (4 * (7 - i))) & 32'hF);
        exp_up.push_back(digits_up[nib]);
        exp_lo.push_back(digits_lo[nib]);
      end
    end else begin
      exp_up.push_back(d[7:0]);
      exp_lo.push_back(d[7:0]);
    end
    @(negedge clk);
    up_if.req_tx  = 1'b1;
    up_if.type_tx = typ;
    up_if.din_tx  = d;
    up_if.tx_rdy  = pick_rdy(rdy_mode, 0);
    k = 0; hs = 0; hs_lo = 0; acks = 0; ack_k = -1; stall = 1'b0;
    held_up = '0; held_lo = '0;
    forever begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        check_eq("first_vld", up_if.tx_vld, 1);
        up_if.din_tx  = $urandom;
        up_if.type_tx = 1'($urandom_range(0, 1));
        if (early) up_if.req_tx = 1'b0;
      end
      if (stall) begin
        check_eq("stall_vld", up_if.tx_vld, 1);
        check_eq("stall_byte_up", up_if.tx_byte, held_up);
        check_eq("stall_byte_lo", lo_if.tx_byte, held_lo);
      end
      if (up_if.ack_tx) begin
        acks++;
        if (ack_k < 0) ack_k = k;
      end
      if (ack_k >= 0 && k > ack_k) begin
        check_eq("rel_vld", up_if.tx_vld, 0);
        if (!early && k <= ack_k + hold) check_eq("rel_busy", up_if.busy, 1);
        if (early && k == ack_k + 2) check_eq("early_rel_exit", up_if.busy, 0);
      end
      r = pick_rdy(rdy_mode, k);
      up_if.tx_rdy = r;
      if (up_if.tx_vld && r) begin
        if (hs < exp_up.size()) check_eq("char_up", up_if.tx_byte, exp_up[hs]);
        else check_eq("extra_char", hs, exp_up.size() - 1);
        stream_q.push_back(up_if.tx_byte);
        hs++;
      end
      if (lo_if.tx_vld && r) begin
        if (hs_lo < exp_lo.size()) check_eq("char_lo", lo_if.tx_byte, exp_lo[hs_lo]);
        hs_lo++;
      end
      stall   = up_if.tx_vld && !r;
      held_up = up_if.tx_byte;
      held_lo = lo_if.tx_byte;
      if (ack_k >= 0 && k >= ack_k + hold) up_if.req_tx = 1'b0;
      if (ack_k >= 0 && !up_if.busy) break;
      if (k > 300) begin
        check_eq("timeout", k, 0);
        break;
      end
    end
    check_eq("handshakes_up", hs, exp_up.size());
    check_eq("handshakes_lo", hs_lo, exp_lo.size());
    check_eq("ack_count", acks, 1);
    if (rdy_mode == 0) check_eq("ack_latency", ack_k, exp_up.size() + 1);
    check_eq("end_busy", up_if.busy, 0);
    up_if.tx_rdy = 1'b0;
  endtask

  logic [7:0] seq_exp[11];

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    up_if.req_tx  = 1'b0;
    up_if.type_tx = 1'b0;
    up_if.din_tx  = '0;
    up_if.tx_rdy  = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_vld", up_if.tx_vld, 0);
    check_eq("rst_byte", up_if.tx_byte, 8'h00);
    check_eq("rst_ack", up_if.ack_tx, 0);
    check_eq("rst_busy", up_if.busy, 0);
    rst = 1'b0;

    // tx_rdy while idle must not start anything
    up_if.tx_rdy = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check_eq("idle_rdy_vld", up_if.tx_vld, 0);
      check_eq("idle_rdy_busy", up_if.busy, 0);
    end
    up_if.tx_rdy = 1'b0;

    run_req(1'b0, 32'h0000_0044, 0, 0, 1'b0);
    run_req(1'b1, 32'h1234_ABCD, 0, 0, 1'b0);
    run_req(1'b1, 32'hDEAD_BEEF, 2, 0, 1'b0);

    // Requester sequence: D - <word 0x10> :
    stream_q.delete();
    seq_exp = '{8'h44, 8'h2D, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h31, 8'h30, 8'h3A};
    run_req(1'b0, 32'h0000_0044, 0, 0, 1'b0);
    run_req(1'b0, 32'h0000_002D, 0, 0, 1'b0);
    run_req(1'b1, 32'h0000_0010, 0, 0, 1'b0);
    run_req(1'b0, 32'h0000_003A, 0, 0, 1'b0);
    check_eq("seq_len", stream_q.size(), 11);
    for (int i = 0; i < 11 && i < stream_q.size(); i++) check_eq("seq_char", stream_q[i], seq_exp[i]);

    run_req(1'b1, 32'h0000_0000, 1, 5, 1'b0);
    run_req(1'b1, 32'h55AA_F00F, 0, 0, 1'b1);
    run_req(1'b0, 32'h0000_0021, 0, 0, 1'b0);

    // Reset while the 3rd character of a word is on the bus
    @(negedge clk);
    up_if.req_tx  = 1'b1;
    up_if.type_tx = 1'b1;
    up_if.din_tx  = 32'hCAFE_F00D;
    up_if.tx_rdy  = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("pre_rst_char", up_if.tx_byte, 8'h46);
    #1 rst = 1'b1;
    #1;
    check_eq("async_rst_vld", up_if.tx_vld, 0);
    check_eq("async_rst_byte", up_if.tx_byte, 8'h00);
    check_eq("async_rst_busy", up_if.busy, 0);
    up_if.req_tx = 1'b0;
    up_if.tx_rdy = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_eq("rst_no_ack", up_if.ack_tx, 0);
    end
    rst = 1'b0;
    run_req(1'b1, 32'h9A3C_0001, 0, 0, 1'b0);

    for (int n = 0; n < 20; n++) begin
      run_req(1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 2),
              $urandom_range(0, 3), 1'($urandom_range(0, 4) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dcp_tx_fmt.md
Name: dcp_tx_fmt

Overview:
- Responder side of the debug-command print handshake (req_tx / type_tx / dout / ack_tx) used by the command processors.
- Accepts one print request, either a raw ASCII byte or a 32-bit word rendered as 8 hex ASCII characters, most significant nibble first.
- Streams the resulting characters to the UART transmitter over a valid/ready byte interface.
- Returns a single-cycle ack_tx once the last character has been handed over.

Parameters:
- HEX_UPPER, 1, 1 = hex digits A-F use 8'h41..8'h46; 0 = a-f use 8'h61..8'h66.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- req_tx  input  1  print request from command processor; level, held until ack_tx seen
- type_tx  input  1  0 = byte mode (send din_tx[7:0] verbatim); 1 = word mode (8 hex chars)
- din_tx  input  32  data to print; sampled only on the acceptance cycle
- ack_tx  output  1  one-cycle pulse: request fully transmitted
- busy  output  1  high in every state except IDLE
- tx_byte  output  8  character to UART transmitter
- tx_vld  output  1  tx_byte valid
- tx_rdy  input  1  UART transmitter accepts tx_byte when tx_vld and tx_rdy are both high

Behaviour:
- Reset (async, rst=1): state=IDLE; ack_tx=0, tx_vld=0, tx_byte=8'h00, busy=0; shift register and counter cleared. Reset mid-transfer aborts immediately with no ack.
- Registers: sh[31:0] (latched data), mode (latched type_tx), cnt[2:0] (characters remaining minus 1).
- All outputs are registered or derived only from state/registers; no combinational path from inputs to outputs.
- States:
  - IDLE: if req_tx=1, latch sh<=din_tx, mode<=type_tx, cnt<=type_tx?7:0, go SEND. Acceptance cycle = t; tx_vld first high at t+1.
  - SEND: tx_vld=1.
    - tx_byte = mode ? hex(sh[31:28]) : sh[7:0]; held stable while tx_rdy=0.
    - On tx_vld & tx_rdy: if cnt==0 go ACK; else cnt<=cnt-1, sh<=sh<<4, stay in SEND.
    - Back-to-back characters are allowed: tx_vld stays high, tx_byte updates the following cycle.
  - ACK: ack_tx=1 for exactly this cycle, tx_vld=0, go REL.
  - REL: wait for req_tx==0, then go IDLE. This prevents re-accepting the same request, since the requester drops req_tx one cycle after seeing ack_tx.
- hex(n): n<10 -> 8'h30+n; n>=10 -> (HEX_UPPER?8'h41:8'h61)+n-10.
- Latency with tx_rdy tied high:
  - byte mode: ack at t+2;
  - word mode: ack at t+9.
- Boundaries:
  - req_tx dropping during SEND is ignored; the transfer completes, ack still pulses, and REL exits on the next cycle.
  - type_tx/din_tx changes after acceptance have no effect.
  - req_tx still high in REL: stay in REL indefinitely, no second transfer.
  - tx_rdy high while tx_vld low: no effect.
  - Word 32'h0000_0000 still sends 8 characters; no leading-zero suppression.

Test Plan:
- Byte mode: req_tx=1, type_tx=0, din_tx=32'h44, tx_rdy=1 -> single tx_byte 8'h44 at t+1, ack_tx pulse at t+2 only, busy low after REL.
- Word mode, upper: din_tx=32'h1234ABCD, type_tx=1, tx_rdy=1 -> bytes 31 32 33 34 41 42 43 44 on consecutive cycles, one ack after the 8th.
- Word mode, HEX_UPPER=0, din_tx=32'hDEADBEEF, tx_rdy toggling 1-of-3 cycles -> bytes 64 65 61 64 62 65 65 66, each held stable until accepted, exactly 8 handshakes.
- Requester model: sequence 'D' (8'h44), '-' (8'h2D), word 32'h00000010, ':' (8'h3A), with req_tx dropped one cycle after ack -> output stream 44 2D 30 30 30 30 30 30 31 30 3A, no duplicated transfers.
- req_tx held high 5 cycles past ack -> stays in REL, no new tx_vld; then release and re-raise -> new transfer accepted.
- rst asserted at 3rd character of a word transfer -> outputs clear asynchronously, no ack_tx; a fresh request after release starts from the first character.
